shift_reg_univ: RTL and testbench

Parametrised universal shift register: the next-generation replacement for the fixed 4-bit SIPO. It supports serial-in/parallel-out, parallel-in/serial-out and parallel-in/parallel-out modes at a configurable width. A bit counter tracks word boundaries, and a valid/ready handshake governs the parallel output. It sits between bit-serial links and word-wide datapaths.

---
 rtl/shift_reg_univ.sv | 172 +++++++++++++++++
 tb/tb_shift_reg_univ.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - parametrised universal shift register (SIPO / PISO / PIPO / hold)
//
// Purpose: bridges bit-serial links and word-wide datapaths. A single shift
// register serves both serial directions, a bit counter marks word
// boundaries, and the parallel output uses a valid/ready handshake.
//
// Build option: SR_MSB_FIRST_EN
//   defined   -> MSB-first serial ordering (SIPO shifts left, PISO emits p_in[WIDTH-1] first)
//   undefined -> LSB-first serial ordering (SIPO shifts right, PISO emits p_in[0] first)
//
// Ports:
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset
//   mode[1:0]    00 SIPO, 01 PISO, 10 PIPO, 11 hold
//   s_in         serial data in (SIPO)
//   s_valid      s_in carries a bit this cycle
//   s_ready      block accepts s_in this cycle (combinational)
//   p_in         parallel data in (PISO/PIPO)
//   p_load       load request for p_in
//   p_out        parallel output word
//   p_valid      p_out holds an unconsumed word
//   p_ready      consumer accepts p_out
//   s_out        serial data out (PISO)
//   s_out_valid  s_out carries a bit this cycle
//   busy         PISO word in flight

module shift_reg_univ #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [1:0]       mode,
  input  logic             s_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_load,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             s_out,
  output logic             s_out_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_SIPO = 2'b00,
    MODE_PISO = 2'b01,
    MODE_PIPO = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] p_out_n;
  logic             p_valid_n;
  logic             busy_n;
  logic             s_out_valid_n;

  logic             mode_chg;
  logic [CW-1:0]    cnt_eff;
  logic             busy_eff;
  logic             sov_eff;
  logic [WIDTH-1:0] sipo_word;
  logic [WIDTH-1:0] piso_shift;

  // The serial output is the outgoing end of sr itself, so it is a flop
  // output with no extra register and the load value appears right after
  // the load edge.
`ifdef SR_MSB_FIRST_EN
  assign sipo_word  = {sr[WIDTH-2:0], s_in};
  assign piso_shift = {sr[WIDTH-2:0], 1'b0};
  assign s_out      = sr[WIDTH-1];
`else
  assign sipo_word  = {s_in, sr[WIDTH-1:1]};
  assign piso_shift = {1'b0, sr[WIDTH-1:1]};
  assign s_out      = sr[0];
`endif

  // Only the completing bit can stall, and only while the previous word is
  // still waiting for its consumer.
  assign s_ready = !((cnt == CNT_LAST) && p_valid && !p_ready);

  // A mode change discards any partial word or serial transfer. The new
  // mode still acts on the same edge, starting from the cleared state, so no
  // cycle is lost when switching.
  assign mode_chg = (mode != mode_q);
  assign cnt_eff  = mode_chg ? '0   : cnt;
  assign busy_eff = mode_chg ? 1'b0 : busy;
  assign sov_eff  = mode_chg ? 1'b0 : s_out_valid;

  always_comb begin
    sr_n          = sr;
    cnt_n         = cnt_eff;
    busy_n        = busy_eff;
    s_out_valid_n = sov_eff;
    p_out_n       = p_out;
    p_valid_n     = p_valid && !p_ready;

    unique case (mode_t'(mode))
      MODE_SIPO: begin
        if (s_valid && s_ready) begin
          sr_n = sipo_word;
          if (cnt_eff == CNT_LAST) begin
            p_out_n   = sipo_word;
            p_valid_n = 1'b1;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt_eff + CW'(1);
          end
        end
      end

      MODE_PISO: begin
        // Accepting a load on the final bit cycle gives gapless words.
        if (p_load && (!busy_eff || (cnt_eff == CNT_LAST))) begin
          sr_n          = p_in;
          cnt_n         = '0;
          busy_n        = 1'b1;
          s_out_valid_n = 1'b1;
        end else if (busy_eff) begin
          if (cnt_eff == CNT_LAST) begin
            cnt_n         = '0;
            busy_n        = 1'b0;
            s_out_valid_n = 1'b0;
          end else begin
            sr_n  = piso_shift;
            cnt_n = cnt_eff + CW'(1);
          end
        end
      end

      MODE_PIPO: begin
        if (p_load && (!p_valid || p_ready)) begin
          p_out_n   = p_in;
          p_valid_n = 1'b1;
        end
      end

      MODE_HOLD: begin
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr          <= '0;
      cnt         <= '0;
      mode_q      <= MODE_SIPO;
      p_out       <= '0;
      p_valid     <= 1'b0;
      busy        <= 1'b0;
      s_out_valid <= 1'b0;
    end else begin
      sr          <= sr_n;
      cnt         <= cnt_n;
      mode_q      <= mode;
      p_out       <= p_out_n;
      p_valid     <= p_valid_n;
      busy        <= busy_n;
      s_out_valid <= s_out_valid_n;
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - directed bench for shift_reg_univ (WIDTH=4, LSB-first)

module tb_shift_reg_univ;

  localparam int WIDTH = 4;

  logic             clk;
  logic             clr_n;
  logic [1:0]       mode;
  logic             s_in;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] p_in;
  logic             p_load;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             s_out;
  logic             s_out_valid;
  logic             busy;

  int errors = 0;
  int checks = 0;

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .mode        (mode),
    .s_in        (s_in),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .p_in        (p_in),
    .p_load      (p_load),
    .p_out       (p_out),
    .p_valid     (p_valid),
    .p_ready     (p_ready),
    .s_out       (s_out),
    .s_out_valid (s_out_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_valid = 1'b1;
    s_in    = b;
    step();
    s_valid = 1'b0;
  endtask

  logic [7:0] piso_exp;

  initial begin
    clr_n   = 1'b0;
    mode    = 2'b00;
    s_in    = 1'b0;
    s_valid = 1'b0;
    p_in    = '0;
    p_load  = 1'b0;
    p_ready = 1'b0;
    // bit i is the i-th expected serial bit: 0,1,0,1 then 0,1,1,0
    piso_exp = 8'b0110_1010;

    step();
    step();
    check("rst_p_out",       p_out,       4'h0);
    check("rst_p_valid",     p_valid,     1'b0);
    check("rst_s_out",       s_out,       1'b0);
    check("rst_s_out_valid", s_out_valid, 1'b0);
    check("rst_busy",        busy,        1'b0);
    check("rst_s_ready",     s_ready,     1'b1);
    clr_n = 1'b1;

    // SIPO: 1,0,0,1 LSB-first -> 4'b1001
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("sipo_not_done_3", p_valid, 1'b0);
    send_bit(1'b1);
    check("sipo_p_out",   p_out,   4'b1001);
    check("sipo_p_valid", p_valid, 1'b1);

    // Backpressure: word pending, three more bits then a stalled 4th
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("bp_s_ready_low", s_ready, 1'b0);
    s_valid = 1'b1;
    s_in    = 1'b0;
    step();
    check("bp_p_out_kept",   p_out,   4'b1001);
    check("bp_s_ready_still", s_ready, 1'b0);
    p_ready = 1'b1;
    #1;
    check("bp_s_ready_release", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    p_ready = 1'b0;
    check("bp_new_word",  p_out,   4'b0110);
    check("bp_p_valid",   p_valid, 1'b1);

    // Reset mid-word after 2 bits
    send_bit(1'b1);
    send_bit(1'b1);
    clr_n = 1'b0;
    #1;
    check("amid_p_out",   p_out,   4'h0);
    check("amid_p_valid", p_valid, 1'b0);
    check("amid_s_ready", s_ready, 1'b1);
    step();
    clr_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("post_rst_3_bits", p_valid, 1'b0);
    send_bit(1'b1);
    check("post_rst_p_out",   p_out,   4'b1101);
    check("post_rst_p_valid", p_valid, 1'b1);

    // Mode change 00->01 with 3 partial bits: cnt cleared, pending word kept
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("mc_s_ready_before", s_ready, 1'b0);
    mode = 2'b01;
    step();
    check("mc_s_ready_after", s_ready,     1'b1);
    check("mc_p_valid_kept",  p_valid,     1'b1);
    check("mc_p_out_kept",    p_out,       4'b1101);
    check("mc_busy",          busy,        1'b0);
    check("mc_s_out_valid",   s_out_valid, 1'b0);
    p_ready = 1'b1;
    step();
    check("mc_consumed", p_valid, 1'b0);
    p_ready = 1'b0;

    // PISO back-to-back: 1010 then 0110 loaded on the final bit cycle;
    // a load on bit 1 must be ignored
    p_in   = 4'b1010;
    p_load = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("piso_bit%0d", i),   s_out,       piso_exp[i]);
      check($sformatf("piso_sov%0d", i),   s_out_valid, 1'b1);
      check($sformatf("piso_busy%0d", i),  busy,        1'b1);
      if (i == 1) begin
        p_load = 1'b1;
        p_in   = 4'b1111;
      end else if (i == 3) begin
        p_load = 1'b1;
        p_in   = 4'b0110;
      end else begin
        p_load = 1'b0;
      end
      step();
    end
    p_load = 1'b0;
    check("piso_end_sov",  s_out_valid, 1'b0);
    check("piso_end_busy", busy,        1'b0);

    // PIPO
    mode = 2'b10;
    step();
    p_in   = 4'h3;
    p_load = 1'b1;
    step();
    check("pipo_load_p_out",   p_out,   4'h3);
    check("pipo_load_p_valid", p_valid, 1'b1);
    p_in = 4'hC;
    step();
    check("pipo_ignored_p_out",   p_out,   4'h3);
    check("pipo_ignored_p_valid", p_valid, 1'b1);
    p_ready = 1'b1;
    step();
    check("pipo_replace_p_out",   p_out,   4'hC);
    check("pipo_replace_p_valid", p_valid, 1'b1);
    p_load = 1'b0;
    step();
    check("pipo_drained", p_valid, 1'b0);
    p_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
